// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory port arbiter.
// Request bundle, FSM states and owner encoding.
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 64;
    localparam int unsigned MEM_DATA_W = 64;
    localparam int unsigned MEM_STRB_W = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic                  we;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr2.sv
// Two-way round-robin picker; the last-grant state is held by the caller.
// Bit 0 of req_i is the IFU, bit 1 the LSU.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_i,
    output owner_e     grant_o,
    output logic       grant_valid_o
);

    always_comb begin
        grant_valid_o = |req_i;
        grant_o       = OWN_IF;
        case (req_i)
            2'b01:   grant_o = OWN_IF;
            2'b10:   grant_o = OWN_LS;
            2'b11:   grant_o = (last_i == OWN_IF) ? OWN_LS : OWN_IF;
            default: grant_o = OWN_IF;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by the IFU and the LSU, with
// round-robin grant, address-window check and response watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       DATA_W   = 64,
    parameter logic [ADDR_W-1:0] MEM_BASE = 64'h8000_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE = 64'h0800_0000,
    parameter int unsigned       TIMEOUT  = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_valid_i,
    output logic                if_req_ready_o,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_resp_valid_o,
    output logic [DATA_W-1:0]   if_resp_data_o,
    output logic                if_resp_err_o,
    input  logic                ls_req_valid_i,
    output logic                ls_req_ready_o,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic                ls_we_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_wstrb_i,
    output logic                ls_resp_valid_o,
    output logic [DATA_W-1:0]   ls_resp_data_o,
    output logic                ls_resp_err_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_resp_valid_i,
    input  logic [DATA_W-1:0]   mem_resp_data_i,
    input  logic                mem_resp_err_i,
    output logic                busy_o,
    output logic                grant_ls_o
);

    localparam logic [ADDR_W:0] WIN_LO = {1'b0, MEM_BASE};
    localparam logic [ADDR_W:0] WIN_HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic [31:0]       cnt_q, cnt_d;

    owner_e            gnt;
    logic              gnt_valid;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic              in_win;
    logic              wd_fire;
    mem_req_t          sel_req;

    arb_rr2 u_rr (
        .req_i         ({ls_req_valid_i, if_req_valid_i}),
        .last_i        (owner_q),
        .grant_o       (gnt),
        .grant_valid_o (gnt_valid)
    );

    assign accept   = (state_q == IDLE) && gnt_valid;
    assign sel_addr = (gnt == OWN_LS) ? ls_addr_i : if_addr_i;
    assign in_win   = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} < WIN_HI);

    // The accept cycle counts toward the budget, so a timeout error
    // pulse lands exactly TIMEOUT cycles after accept.
    assign wd_fire = (TIMEOUT != 0) && ((cnt_q + 32'd2) >= TIMEOUT);

    always_comb begin
        sel_req       = '0;
        sel_req.addr  = MEM_ADDR_W'(sel_addr);
        if (gnt == OWN_LS) begin
            sel_req.we    = ls_we_i;
            sel_req.wdata = MEM_DATA_W'(ls_wdata_i);
            sel_req.wstrb = MEM_STRB_W'(ls_wstrb_i);
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt;
                    req_d   = sel_req;
                    cnt_d   = '0;
                    rdata_d = '0;
                    rerr_d  = !in_win;
                    state_d = in_win ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 32'd1;
                if (wd_fire) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    state_d = RESP;
                end else if (mem_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_resp_valid_i) begin
                    rdata_d = mem_resp_data_i;
                    rerr_d  = mem_resp_err_i;
                    state_d = RESP;
                end else if (wd_fire) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            req_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign if_req_ready_o = accept && (gnt == OWN_IF);
    assign ls_req_ready_o = accept && (gnt == OWN_LS);

    assign mem_req_valid_o = (state_q == ISSUE);
    assign mem_addr_o      = req_q.addr[ADDR_W-1:0];
    assign mem_we_o        = req_q.we;
    assign mem_wdata_o     = req_q.wdata[DATA_W-1:0];
    assign mem_wstrb_o     = req_q.wstrb[DATA_W/8-1:0];

    assign if_resp_valid_o = (state_q == RESP) && (owner_q == OWN_IF);
    assign ls_resp_valid_o = (state_q == RESP) && (owner_q == OWN_LS);
    assign if_resp_data_o  = if_resp_valid_o ? rdata_q : '0;
    assign ls_resp_data_o  = ls_resp_valid_o ? rdata_q : '0;
    assign if_resp_err_o   = if_resp_valid_o && rerr_q;
    assign ls_resp_err_o   = ls_resp_valid_o && rerr_q;

    assign busy_o     = (state_q != IDLE);
    assign grant_ls_o = (owner_q == OWN_LS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, latency, window
// errors, watchdog, reset mid-transaction and memory error pass-through.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_valid_i;
    logic        if_req_ready_o;
    logic [63:0] if_addr_i;
    logic        if_resp_valid_o;
    logic [63:0] if_resp_data_o;
    logic        if_resp_err_o;
    logic        ls_req_valid_i;
    logic        ls_req_ready_o;
    logic [63:0] ls_addr_i;
    logic        ls_we_i;
    logic [63:0] ls_wdata_i;
    logic [7:0]  ls_wstrb_i;
    logic        ls_resp_valid_o;
    logic [63:0] ls_resp_data_o;
    logic        ls_resp_err_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [63:0] mem_addr_o;
    logic        mem_we_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_resp_valid_i;
    logic [63:0] mem_resp_data_i;
    logic        mem_resp_err_i;
    logic        busy_o;
    logic        grant_ls_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .TIMEOUT(8)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .if_req_valid_i   (if_req_valid_i),
        .if_req_ready_o   (if_req_ready_o),
        .if_addr_i        (if_addr_i),
        .if_resp_valid_o  (if_resp_valid_o),
        .if_resp_data_o   (if_resp_data_o),
        .if_resp_err_o    (if_resp_err_o),
        .ls_req_valid_i   (ls_req_valid_i),
        .ls_req_ready_o   (ls_req_ready_o),
        .ls_addr_i        (ls_addr_i),
        .ls_we_i          (ls_we_i),
        .ls_wdata_i       (ls_wdata_i),
        .ls_wstrb_i       (ls_wstrb_i),
        .ls_resp_valid_o  (ls_resp_valid_o),
        .ls_resp_data_o   (ls_resp_data_o),
        .ls_resp_err_o    (ls_resp_err_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_we_o         (mem_we_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wstrb_o      (mem_wstrb_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_err_i   (mem_resp_err_i),
        .busy_o           (busy_o),
        .grant_ls_o       (grant_ls_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    logic [63:0] wd [5];
    logic [63:0] rd [4];
    logic [63:0] bad_addr [2];
    logic        exp_ls;

    initial begin
        wd[0] = 64'h1111_2222_3333_4444;
        wd[1] = 64'h5555_6666_7777_8888;
        wd[2] = 64'h9999_AAAA_BBBB_CCCC;
        wd[3] = 64'hDDDD_EEEE_FFFF_0000;
        wd[4] = 64'h0123_4567_89AB_CDEF;
        rd[0] = 64'hA0; rd[1] = 64'hA1; rd[2] = 64'hA2; rd[3] = 64'hA3;
        bad_addr[0] = 64'h7FFF_FFF8;
        bad_addr[1] = 64'h8800_0000;

        rst_i = 1'b1;
        if_req_valid_i = 0; if_addr_i = 0;
        ls_req_valid_i = 0; ls_addr_i = 0; ls_we_i = 0;
        ls_wdata_i = 0; ls_wstrb_i = 0;
        mem_req_ready_i = 0; mem_resp_valid_i = 0;
        mem_resp_data_i = 0; mem_resp_err_i = 0;

        nxt(); nxt();
        mid();
        chk("rst_busy", busy_o, 0);
        chk("rst_grant_ls", grant_ls_o, 0);
        chk("rst_mem_valid", mem_req_valid_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_if_ready", if_req_ready_o, 0);
        chk("rst_if_resp", if_resp_valid_o, 0);
        chk("rst_ls_resp", ls_resp_valid_o, 0);
        chk("rst_if_data", if_resp_data_o, 0);
        nxt();
        rst_i = 1'b0;

        // IFU read, nominal latency
        if_req_valid_i = 1; if_addr_i = 64'h8000_0000;
        mid();
        chk("t1_if_ready", if_req_ready_o, 1);
        chk("t1_ls_ready", ls_req_ready_o, 0);
        chk("t1_mem_valid_T", mem_req_valid_o, 0);
        nxt();
        if_req_valid_i = 0; mem_req_ready_i = 1;
        mid();
        chk("t1_mem_valid_T1", mem_req_valid_o, 1);
        chk("t1_mem_addr", mem_addr_o, 64'h8000_0000);
        chk("t1_mem_we", mem_we_o, 0);
        chk("t1_busy", busy_o, 1);
        chk("t1_grant_ls", grant_ls_o, 0);
        nxt();
        mem_req_ready_i = 0; mem_resp_valid_i = 1;
        mem_resp_data_i = 64'hDEAD_BEEF;
        mid();
        chk("t1_if_resp_T2", if_resp_valid_o, 0);
        nxt();
        mem_resp_valid_i = 0; mem_resp_data_i = 0;
        mid();
        chk("t1_if_resp_T3", if_resp_valid_o, 1);
        chk("t1_if_data", if_resp_data_o, 64'hDEAD_BEEF);
        chk("t1_if_err", if_resp_err_o, 0);
        chk("t1_ls_resp", ls_resp_valid_o, 0);
        nxt();
        mid();
        chk("t1_idle_busy", busy_o, 0);
        chk("t1_idle_if_resp", if_resp_valid_o, 0);
        nxt();

        // Both requesters always valid: LSU, IFU, LSU, IFU
        if_req_valid_i = 1; if_addr_i = 64'h8000_0200;
        ls_req_valid_i = 1; ls_addr_i = 64'h8000_0100;
        ls_we_i = 1; ls_wstrb_i = 8'h0F; ls_wdata_i = wd[0];
        for (int k = 0; k < 4; k++) begin
            exp_ls = (k % 2 == 0);
            mid();
            chk("t2_ls_ready", ls_req_ready_o, exp_ls);
            chk("t2_if_ready", if_req_ready_o, !exp_ls);
            nxt();
            if (exp_ls) begin
                ls_wdata_i = wd[k/2 + 1];
                ls_wstrb_i = 8'hF0;
            end else begin
                ls_wstrb_i = 8'h0F;
            end
            for (int c = 0; c < 4; c++) begin
                if (c == 3) mem_req_ready_i = 1;
                mid();
                chk("t2_mem_valid", mem_req_valid_o, 1);
                chk("t2_mem_addr", mem_addr_o,
                    exp_ls ? 64'h8000_0100 : 64'h8000_0200);
                chk("t2_mem_we", mem_we_o, exp_ls);
                chk("t2_mem_wdata", mem_wdata_o, exp_ls ? wd[k/2] : 64'h0);
                chk("t2_mem_wstrb", mem_wstrb_o, exp_ls ? 8'h0F : 8'h00);
                chk("t2_grant_ls", grant_ls_o, exp_ls);
                nxt();
            end
            mem_req_ready_i = 0; mem_resp_valid_i = 1;
            mem_resp_data_i = rd[k];
            mid();
            chk("t2_wait_mem_valid", mem_req_valid_o, 0);
            chk("t2_wait_ls_resp", ls_resp_valid_o, 0);
            nxt();
            mem_resp_valid_i = 0;
            mid();
            chk("t2_ls_resp", ls_resp_valid_o, exp_ls);
            chk("t2_if_resp", if_resp_valid_o, !exp_ls);
            chk("t2_ls_data", ls_resp_data_o, exp_ls ? rd[k] : 64'h0);
            chk("t2_if_data", if_resp_data_o, exp_ls ? 64'h0 : rd[k]);
            chk("t2_resp_if_ready", if_req_ready_o, 0);
            chk("t2_resp_ls_ready", ls_req_ready_o, 0);
            nxt();
        end
        if_req_valid_i = 0; ls_req_valid_i = 0;
        ls_we_i = 0; ls_wstrb_i = 0; ls_wdata_i = 0;
        mid();
        chk("t2_end_busy", busy_o, 0);
        nxt();

        // Out-of-window addresses
        for (int a = 0; a < 2; a++) begin
            ls_req_valid_i = 1; ls_addr_i = bad_addr[a];
            mid();
            chk("t3_ls_ready", ls_req_ready_o, 1);
            chk("t3_mem_valid_T", mem_req_valid_o, 0);
            nxt();
            ls_req_valid_i = 0;
            mid();
            chk("t3_ls_resp", ls_resp_valid_o, 1);
            chk("t3_ls_err", ls_resp_err_o, 1);
            chk("t3_ls_data", ls_resp_data_o, 0);
            chk("t3_mem_valid_T1", mem_req_valid_o, 0);
            chk("t3_if_resp", if_resp_valid_o, 0);
            nxt();
            mid();
            chk("t3_mem_valid_T2", mem_req_valid_o, 0);
            chk("t3_busy", busy_o, 0);
            nxt();
        end
        ls_req_valid_i = 1; ls_addr_i = 64'h87FF_FFF8;
        mid();
        chk("t3_top_ready", ls_req_ready_o, 1);
        nxt();
        ls_req_valid_i = 0; mem_req_ready_i = 1;
        mid();
        chk("t3_top_mem_valid", mem_req_valid_o, 1);
        chk("t3_top_mem_addr", mem_addr_o, 64'h87FF_FFF8);
        nxt();
        mem_req_ready_i = 0; mem_resp_valid_i = 1;
        mem_resp_data_i = 64'h1234_5678;
        mid();
        nxt();
        mem_resp_valid_i = 0;
        mid();
        chk("t3_top_resp", ls_resp_valid_o, 1);
        chk("t3_top_err", ls_resp_err_o, 0);
        chk("t3_top_data", ls_resp_data_o, 64'h1234_5678);
        chk("t3_top_if_data", if_resp_data_o, 0);
        nxt();

        // Watchdog: memory never responds
        ls_req_valid_i = 1; ls_addr_i = 64'h8000_0008;
        mid();
        chk("t4_ls_ready", ls_req_ready_o, 1);
        nxt();
        ls_req_valid_i = 0; mem_req_ready_i = 1;
        for (int i = 1; i < 8; i++) begin
            mid();
            chk("t4_no_resp", ls_resp_valid_o, 0);
            nxt();
            mem_req_ready_i = 0;
        end
        mid();
        chk("t4_to_resp", ls_resp_valid_o, 1);
        chk("t4_to_err", ls_resp_err_o, 1);
        chk("t4_to_data", ls_resp_data_o, 0);
        chk("t4_to_mem_valid", mem_req_valid_o, 0);
        nxt();
        mem_resp_valid_i = 1; mem_resp_data_i = 64'hBAD;
        mid();
        chk("t4_idle_busy", busy_o, 0);
        chk("t4_idle_ls_resp", ls_resp_valid_o, 0);
        nxt();
        mem_resp_valid_i = 0;
        mid();
        chk("t4_stale_ls_resp", ls_resp_valid_o, 0);
        chk("t4_stale_if_resp", if_resp_valid_o, 0);
        chk("t4_stale_busy", busy_o, 0);
        nxt();

        // Reset while in WAIT
        if_req_valid_i = 1; if_addr_i = 64'h8000_0010;
        mid();
        chk("t5_if_ready", if_req_ready_o, 1);
        nxt();
        if_req_valid_i = 0; mem_req_ready_i = 1;
        mid();
        nxt();
        mem_req_ready_i = 0; rst_i = 1;
        mid();
        chk("t5_wait_busy", busy_o, 1);
        nxt();
        rst_i = 0; mem_resp_valid_i = 1; mem_resp_data_i = 64'h5555;
        mid();
        chk("t5_busy", busy_o, 0);
        chk("t5_mem_valid", mem_req_valid_o, 0);
        chk("t5_if_resp", if_resp_valid_o, 0);
        chk("t5_grant_ls", grant_ls_o, 0);
        chk("t5_mem_addr", mem_addr_o, 0);
        nxt();
        mem_resp_valid_i = 0;
        mid();
        chk("t5_stale_if_resp", if_resp_valid_o, 0);
        chk("t5_stale_busy", busy_o, 0);
        nxt();

        // Memory error on an IFU read
        if_req_valid_i = 1; if_addr_i = 64'h8000_0018;
        mid();
        chk("t6_if_ready", if_req_ready_o, 1);
        nxt();
        if_req_valid_i = 0; mem_req_ready_i = 1;
        mid();
        chk("t6_mem_valid", mem_req_valid_o, 1);
        chk("t6_mem_addr", mem_addr_o, 64'h8000_0018);
        nxt();
        mem_req_ready_i = 0; mem_resp_valid_i = 1;
        mem_resp_data_i = 64'hFEED; mem_resp_err_i = 1;
        mid();
        nxt();
        mem_resp_valid_i = 0; mem_resp_err_i = 0; mem_resp_data_i = 0;
        mid();
        chk("t6_if_resp", if_resp_valid_o, 1);
        chk("t6_if_err", if_resp_err_o, 1);
        chk("t6_if_data", if_resp_data_o, 64'hFEED);
        chk("t6_ls_resp", ls_resp_valid_o, 0);
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction fetch unit (IFU requester) and the load/store path (LSU requester) of the multi-cycle core.
- Allows one outstanding transaction at a time.
- Applies round-robin arbitration, an address-window check and a response watchdog.
- Errors are returned to the requester; the requester raises FetchError or MemAccessError toward the monitor.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.
- MEM_BASE, 64'h8000_0000, first legal address.
- MEM_SIZE, 64'h0800_0000, legal window size in bytes.
- TIMEOUT, 255, cycles allowed in ISSUE+WAIT before a timeout error; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- if_req_valid_i  in  1  IFU request valid
- if_req_ready_o  out  1  IFU request accepted this cycle
- if_addr_i  in  ADDR_W  IFU address; always a read
- if_resp_valid_o  out  1  IFU response pulse
- if_resp_data_o  out  DATA_W  IFU read data
- if_resp_err_o  out  1  IFU error; valid with if_resp_valid_o
- ls_req_valid_i  in  1  LSU request valid
- ls_req_ready_o  out  1  LSU request accepted this cycle
- ls_addr_i  in  ADDR_W  LSU address
- ls_we_i  in  1  LSU write enable
- ls_wdata_i  in  DATA_W  LSU write data
- ls_wstrb_i  in  DATA_W/8  LSU byte strobes
- ls_resp_valid_o  out  1  LSU response pulse
- ls_resp_data_o  out  DATA_W  LSU read data
- ls_resp_err_o  out  1  LSU error; valid with ls_resp_valid_o
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_resp_valid_i  in  1  memory response valid
- mem_resp_data_i  in  DATA_W  memory read data
- mem_resp_err_i  in  1  memory-side error
- busy_o  out  1  state != IDLE
- grant_ls_o  out  1  current/last owner is LSU (0 = IFU)

Behaviour:
- Reset values:
  - state IDLE; last_grant = IFU, so the first tie goes to the LSU.
  - All *_valid_o, *_ready_o, *_err_o, busy_o, grant_ls_o = 0.
  - Data/address outputs = 0; watchdog counter = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant selection:
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not last_grant.
  - None valid: stay in IDLE.
  - Granted *_req_ready_o is combinational (IDLE & granted valid); the ungranted ready stays 0.
  - On accept: latch the request fields (IFU: we=0, wstrb=0, wdata=0) and update last_grant and grant_ls_o.
  - Address-window check: if addr < MEM_BASE or addr >= MEM_BASE+MEM_SIZE (computed without overflow, ADDR_W+1 bits), go to RESP with err=1, data=0, and never drive mem_req_valid_o. Otherwise go to ISSUE.
- ISSUE:
  - mem_req_valid_o=1 with latched fields, held stable until mem_req_ready_i.
  - On ready go to WAIT.
- WAIT:
  - On mem_resp_valid_i, latch data and err, then go to RESP.
  - A response arriving in the same cycle as the ISSUE handshake is not accepted; memory responds no earlier than the cycle after acceptance.
- RESP:
  - Assert exactly one *_resp_valid_o (the owner's) for one cycle with the latched data/err.
  - The other requester's response outputs stay 0. Return to IDLE.
  - A new grant is possible in the following cycle; no grant is given in the RESP cycle.
- Watchdog:
  - Counter clears on accept and increments each cycle in ISSUE or WAIT.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT, go to RESP with err=1, data=0, and drop mem_req_valid_o.
  - A stale mem_resp_valid_i later received in IDLE/ISSUE/RESP is ignored.
- Latency: accept at cycle T; mem_req_valid_o from T+1. With ready at T+1 and response at T+2, the requester response pulse is at T+3.
- Requester rules:
  - A requester may drop valid before it is accepted, with no side effects.
  - Fields are sampled only in the accept cycle.
- Reset mid-transaction: next cycle is IDLE, all outputs at reset values, no response pulse. The in-flight memory response is discarded as stale.
- Both requesters valid continuously: grants strictly alternate IFU/LSU.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner enum {OWN_IF, OWN_LS}
  - struct mem_req_t {addr, we, wdata, wstrb}
  - localparam for strobe width
- Sub-module arb_rr2: 2-way round-robin picker (req[1:0], last, grant, grant_valid), purely combinational; the last_grant register lives in the parent.

Test Plan:
- IFU only, addr 0x8000_0000, mem ready at once, response at next cycle with data 0xDEAD_BEEF -> if_req_ready pulse at T, mem_req_valid T+1, if_resp_valid at T+3 with data 0xDEAD_BEEF, err 0; ls_resp_valid stays 0.
- Both requesters valid for 4 transactions -> grant order LSU, IFU, LSU, IFU; each mem write from the LSU carries its latched wdata/wstrb 0x0F unchanged while mem_req_ready is held low for 3 cycles.
- LSU addr 0x7FFF_FFF8 and addr 0x8800_0000 -> ls_resp_err=1 at T+1, mem_req_valid never asserted; addr 0x87FF_FFF8 passes to ISSUE.
- TIMEOUT=8, memory never responds -> ls_resp_valid with err=1, data=0 eight cycles after accept. A later mem_resp_valid pulse in IDLE produces no response.
- rst_i asserted in WAIT -> next cycle busy_o=0, all valids 0, no response pulse. Next IFU request is granted normally.
- mem_resp_err_i=1 on an IFU read -> if_resp_err=1, and the error is passed through with the latched data.
